// File: rtl/vdcorput_32bit.sv
// Sequential base-BASE van der Corput generator.
// Each accepted pop advances the index k (mod BASE**SCALE) and emits the
// digit-reversed radical inverse of k as an integer numerator over
// BASE**SCALE. One base-BASE digit is peeled off per clock, so a conversion
// takes SCALE cycles in CALC followed by a one-cycle valid pulse.
module vdcorput_32bit #(
  parameter int BASE  = 2,
  parameter int SCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pop_enable,
  input  logic [31:0] seed,
  input  logic        reseed_enable,
  output logic [31:0] vdc_out,
  output logic        valid,
  output logic        busy
);

  // BASE**SCALE, saturated just above 2^32 so oversized configurations are
  // detected instead of silently wrapping in 64 bits.
  function automatic longint unsigned pow_sat(input int b, input int s);
    longint unsigned r;
    r = 64'd1;
    for (int j = 0; j < s; j++) begin
      r = r * 64'(b);
      if (r > 64'h1_0000_0000) begin
        r = 64'h2_0000_0000;
      end
    end
    return r;
  endfunction

  localparam longint unsigned M_L = pow_sat(BASE, SCALE);
  localparam logic [31:0] M_MAX   = 32'(M_L - 64'd1);
  localparam logic [31:0] BASE_W  = 32'(BASE);
  localparam logic [5:0]  LAST_IX = 6'(SCALE - 1);

  // The index fits in 32 bits only while BASE**SCALE <= 2^32.
  if (BASE < 2 || BASE > 255 || SCALE < 1 || M_L > 64'h1_0000_0000) begin : g_param_check
    $error("vdcorput_32bit: BASE must be 2..255 and BASE**SCALE must not exceed 2**32");
  end

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] work_q,  work_d;
  logic [31:0] acc_q,   acc_d;
  logic [5:0]  idx_q,   idx_d;
  logic [31:0] vdc_q,   vdc_d;
  logic        valid_q, valid_d;
  logic        busy_q,  busy_d;

  logic [31:0] count_inc;
  logic [31:0] seed_mod;
  logic [31:0] acc_step;
  logic        last_digit;

  // Index successor with wrap at M-1; the comparison form avoids needing a
  // 33-bit adder when M is exactly 2^32.
  assign count_inc  = (count_q == M_MAX) ? 32'd0 : count_q + 32'd1;
  // Reduction by a constant modulus; when M is 2^32 this is the identity.
  assign seed_mod   = 32'({32'd0, seed} % M_L);
  // Shift the accumulator up one digit and append the current low digit of work.
  // acc never exceeds M-1, so the 32-bit product cannot overflow.
  assign acc_step   = acc_q * BASE_W + (work_q % BASE_W);
  assign last_digit = (idx_q == LAST_IX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: reseed forces IDLE, pop starts a conversion,
  // the final digit returns to IDLE
  always_comb begin
    state_d = state_q;
    if (reseed_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pop_enable) state_d = CALC;
        CALC:    if (last_digit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next-values for each state
  always_comb begin
    count_d = count_q;
    work_d  = work_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    vdc_d   = vdc_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    if (reseed_enable) begin
      // Aborts any conversion in flight; vdc_out keeps its old value.
      count_d = seed_mod;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_enable) begin
            count_d = count_inc;
            work_d  = count_inc;
            acc_d   = 32'd0;
            idx_d   = 6'd0;
            busy_d  = 1'b1;
          end
        end
        CALC: begin
          acc_d  = acc_step;
          work_d = work_q / BASE_W;
          idx_d  = idx_q + 6'd1;
          if (last_digit) begin
            vdc_d   = acc_step;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
      work_q  <= 32'd0;
      acc_q   <= 32'd0;
      idx_q   <= 6'd0;
      vdc_q   <= 32'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      vdc_q   <= vdc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign vdc_out = vdc_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_vdcorput_32bit.sv
// Testbench for vdcorput_32bit. Four instances with different BASE/SCALE
// share one stimulus bus; each is checked against a digit-sum reference.
module tb_vdcorput_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pop_enable = 1'b0;
  logic        reseed_enable = 1'b0;
  logic [31:0] seed = 32'd0;

  logic [31:0] vo [4];
  logic        va [4];
  logic        bz [4];

  int compared = 0;
  int mismatched = 0;

  int base_t  [4] = '{2, 3, 2, 7};
  int scale_t [4] = '{16, 10, 4, 10};
  longint mk   [4];   // model index k
  longint held [4];   // model of the value vdc_out should be holding
  logic [31:0] g_ov [4][8];
  int          g_n  [4];

  always #5 clk = ~clk;

  vdcorput_32bit #(.BASE(2), .SCALE(16)) u_b2s16 (
    .clk(clk), .rst(rst), .pop_enable(pop_enable), .seed(seed), .reseed_enable(reseed_enable),
    .vdc_out(vo[0]), .valid(va[0]), .busy(bz[0]));
  vdcorput_32bit #(.BASE(3), .SCALE(10)) u_b3s10 (
    .clk(clk), .rst(rst), .pop_enable(pop_enable), .seed(seed), .reseed_enable(reseed_enable),
    .vdc_out(vo[1]), .valid(va[1]), .busy(bz[1]));
  vdcorput_32bit #(.BASE(2), .SCALE(4)) u_b2s4 (
    .clk(clk), .rst(rst), .pop_enable(pop_enable), .seed(seed), .reseed_enable(reseed_enable),
    .vdc_out(vo[2]), .valid(va[2]), .busy(bz[2]));
  vdcorput_32bit #(.BASE(7), .SCALE(10)) u_b7s10 (
    .clk(clk), .rst(rst), .pop_enable(pop_enable), .seed(seed), .reseed_enable(reseed_enable),
    .vdc_out(vo[3]), .valid(va[3]), .busy(bz[3]));

  function automatic longint mpow(input int b, input int s);
    longint r = 1;
    for (int j = 0; j < s; j++) r = r * b;
    return r;
  endfunction

  // Radical inverse as a digit sum: d_j * b^(s-1-j)
  function automatic longint vdc_ref(input longint k, input int b, input int s);
    longint r = 0;
    longint kk = k;
    for (int j = 0; j < s; j++) begin
      r = r + (kk % b) * mpow(b, s - 1 - j);
      kk = kk / b;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      mk[d] = 0;
      held[d] = 0;
    end
  endtask

  // Hold pop_enable for 'hold' clock edges, then observe until all idle.
  task automatic pop_window(input int hold);
    int bc [4];
    for (int d = 0; d < 4; d++) begin
      g_n[d] = 0;
      bc[d] = 0;
      for (int m = 0; m < 8; m++) g_ov[d][m] = 32'hDEAD_BEEF;
    end
    begin
      int oo [4][8];
      @(negedge clk);
      pop_enable = 1'b1;
      for (int o = 0; o < hold + 24; o++) begin
        @(negedge clk);
        if (o == hold - 1) pop_enable = 1'b0;
        for (int d = 0; d < 4; d++) begin
          if (va[d]) begin
            if (g_n[d] < 8) begin
              oo[d][g_n[d]] = o;
              g_ov[d][g_n[d]] = vo[d];
            end
            g_n[d]++;
          end
          if (bz[d]) bc[d]++;
        end
      end
      for (int d = 0; d < 4; d++) begin
        int s = scale_t[d];
        int exp_n = (hold + s) / (s + 1);
        longint mm = mpow(base_t[d], s);
        compared++;
        if (g_n[d] !== exp_n) begin
          mismatched++;
          $display("FAIL valid_count dut%0d hold=%0d: got %0d expected %0d", d, hold, g_n[d], exp_n);
        end
        for (int m = 0; m < exp_n; m++) begin
          longint ev;
          mk[d] = (mk[d] + 1) % mm;
          ev = vdc_ref(mk[d], base_t[d], s);
          held[d] = ev;
          if (m < g_n[d] && m < 8) begin
            compared++;
            if (g_ov[d][m] !== 32'(ev)) begin
              mismatched++;
              $display("FAIL vdc_value dut%0d k=%0d: got %0d expected %0d", d, mk[d], g_ov[d][m], ev);
            end
            compared++;
            if (oo[d][m] !== m * (s + 1) + s) begin
              mismatched++;
              $display("FAIL valid_latency dut%0d #%0d: got cycle %0d expected %0d", d, m, oo[d][m], m * (s + 1) + s);
            end
          end
        end
        compared++;
        if (bc[d] !== exp_n * s) begin
          mismatched++;
          $display("FAIL busy_cycles dut%0d: got %0d expected %0d", d, bc[d], exp_n * s);
        end
        compared++;
        if (vo[d] !== 32'(held[d])) begin
          mismatched++;
          $display("FAIL vdc_hold dut%0d: got %0d expected %0d", d, vo[d], held[d]);
        end
      end
    end
  endtask

  // Watch for 'n' cycles: no valid, no busy, vdc_out unchanged.
  task automatic expect_quiet(input int n, input string tag);
    int vc [4];
    int bc [4];
    for (int d = 0; d < 4; d++) begin
      vc[d] = 0;
      bc[d] = 0;
    end
    for (int o = 0; o < n; o++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (va[d]) vc[d]++;
        if (bz[d]) bc[d]++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (vc[d] !== 0 || bc[d] !== 0) begin
        mismatched++;
        $display("FAIL %s_quiet dut%0d: got valid=%0d busy=%0d cycles expected 0/0", tag, d, vc[d], bc[d]);
      end
      compared++;
      if (vo[d] !== 32'(held[d])) begin
        mismatched++;
        $display("FAIL %s_hold dut%0d: got %0d expected %0d", tag, d, vo[d], held[d]);
      end
    end
  endtask

  task automatic do_reseed(input logic [31:0] sv, input logic with_pop);
    @(negedge clk);
    seed = sv;
    reseed_enable = 1'b1;
    pop_enable = with_pop;
    @(negedge clk);
    reseed_enable = 1'b0;
    pop_enable = 1'b0;
    for (int d = 0; d < 4; d++) mk[d] = longint'(sv) % mpow(base_t[d], scale_t[d]);
    expect_quiet(20, "reseed");
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_const(input int d, input int m, input logic [31:0] ev, input string tag);
    compared++;
    if (g_ov[d][m] !== ev) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0d expected %0d", tag, d, g_ov[d][m], ev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (vo[d] !== 32'd0 || va[d] !== 1'b0 || bz[d] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_state dut%0d: got vdc=%0d valid=%0b busy=%0b expected 0/0/0", d, vo[d], va[d], bz[d]);
      end
    end
    rst = 1'b0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_known_values();
    logic [31:0] e0 [4] = '{32'd32768, 32'd16384, 32'd49152, 32'd8192};
    logic [31:0] e1 [3] = '{32'd19683, 32'd39366, 32'd6561};
    logic [31:0] e3 [3] = '{32'd40353607, 32'd80707214, 32'd121060821};
    for (int p = 0; p < 4; p++) begin
      pop_window(1);
      check_const(0, 0, e0[p], "known_b2");
      if (p < 3) begin
        check_const(1, 0, e1[p], "known_b3");
        check_const(3, 0, e3[p], "known_b7");
      end
      $display("test_known_values pop %0d: dut0=%0d dut1=%0d dut3=%0d", p, g_ov[0][0], g_ov[1][0], g_ov[3][0]);
    end
  endtask

  task automatic test_reseed();
    do_reseed(32'd7, 1'b0);
    pop_window(1);
    check_const(0, 0, 32'd4096, "reseed7_b2");
    $display("test_reseed: dut0=%0d", g_ov[0][0]);
  endtask

  task automatic test_abort(input logic [31:0] sv);
    @(negedge clk);
    pop_enable = 1'b1;
    @(negedge clk);
    pop_enable = 1'b0;
    repeat (2) @(negedge clk);
    seed = sv;
    reseed_enable = 1'b1;
    @(negedge clk);
    reseed_enable = 1'b0;
    for (int d = 0; d < 4; d++) mk[d] = longint'(sv) % mpow(base_t[d], scale_t[d]);
    expect_quiet(24, "abort");
    pop_window(1);
    $display("test_abort seed=%0d: next dut0=%0d", sv, g_ov[0][0]);
  endtask

  task automatic test_wrap();
    do_reseed(32'd15, 1'b0);
    pop_window(1);
    check_const(2, 0, 32'd0, "wrap0_b2s4");
    pop_window(1);
    check_const(2, 0, 32'd8, "wrap1_b2s4");
    do_reseed(32'd20, 1'b0);
    pop_window(1);
    check_const(2, 0, 32'd10, "seed20_b2s4");
    $display("test_wrap: dut2=%0d", g_ov[2][0]);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e3 [3] = '{32'd40353607, 32'd80707214, 32'd121060821};
    reset_dut();
    pop_window(33);
    for (int m = 0; m < 3; m++) check_const(3, m, e3[m], "b2b_b7");
    $display("test_back_to_back: dut3 valids=%0d", g_n[3]);
  endtask

  task automatic test_reseed_with_pop();
    do_reseed(32'd3, 1'b1);
    pop_window(1);
    $display("test_reseed_with_pop: dut0=%0d", g_ov[0][0]);
  endtask

  task automatic test_rst_mid_calc();
    reset_dut();
    pop_window(1);
    pop_window(1);
    @(negedge clk);
    pop_enable = 1'b1;
    @(negedge clk);
    pop_enable = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      compared++;
      if (vo[d] !== 32'd0 || va[d] !== 1'b0 || bz[d] !== 1'b0) begin
        mismatched++;
        $display("FAIL async_rst dut%0d: got vdc=%0d valid=%0b busy=%0b expected 0/0/0", d, vo[d], va[d], bz[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    expect_quiet(20, "rst_mid");
    pop_window(1);
    check_const(0, 0, 32'd32768, "after_rst_b2");
    $display("test_rst_mid_calc: dut0=%0d", g_ov[0][0]);
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      int r = $urandom_range(0, 3);
      case (r)
        0: begin
          logic [31:0] sv = $urandom;
          logic wp = 1'($urandom_range(0, 1));
          do_reseed(sv, wp);
          $display("test_random %0d: reseed %0d pop=%0b", it, sv, wp);
        end
        3: begin
          logic [31:0] sv = $urandom;
          test_abort(sv);
        end
        default: begin
          int h = $urandom_range(1, 40);
          pop_window(h);
          $display("test_random %0d: pop hold=%0d dut0=%0d", it, h, g_ov[0][0]);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_reseed();
    test_abort(32'd100);
    test_wrap();
    test_back_to_back();
    test_reseed_with_pop();
    test_rst_mid_calc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
